// File: rtl/spi_slave_checker_if.sv
// Bus bundle between the SPI master test generator / control logic and the
// SPI slave checker: SPI pins, enables and the check/status results.
interface spi_slave_checker_if;
    logic       rx_en;
    logic       mode_select;
    logic       spi_clk;
    logic       spi_mosi;
    logic       spi_miso;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [9:0] match_count;
    logic [9:0] err_count;
    logic [9:0] byte_count;
    logic       frame_done;
    logic       frag_err;

    modport slave (
        input  rx_en, mode_select, spi_clk, spi_mosi,
        output spi_miso, rx_data, rx_valid, match_count, err_count,
               byte_count, frame_done, frag_err
    );

    modport master (
        output rx_en, mode_select, spi_clk, spi_mosi,
        input  spi_miso, rx_data, rx_valid, match_count, err_count,
               byte_count, frame_done, frag_err
    );
endinterface

// File: rtl/spi_slave_checker.sv
// SPI slave receive/check stage: deserialises MSB-first bytes, checks them
// against an incrementing sequence, counts results per frame and echoes on MISO.
module spi_slave_checker #(
    parameter int SYNC_STAGES  = 2,
    parameter int IDLE_TIMEOUT = 16,
    parameter int FRAME_BYTES  = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_slave_checker_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int              TW        = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [TW-1:0]   TO_RELOAD = TW'(IDLE_TIMEOUT - 1);
    localparam logic [TW-1:0]   TO_ONE    = TW'(1);
    localparam logic [TW-1:0]   TO_ZERO   = TW'(0);
    localparam logic [9:0]      LAST_IDX  = 10'(FRAME_BYTES - 1);

    // MISO presents the echo byte MSB first, indexed by the bits already taken.
    function automatic logic echo_bit(input logic [7:0] echo, input logic [2:0] cnt);
        return echo[3'd7 - cnt];
    endfunction

    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   sclk_hist_r;
    logic                   sclk_s;
    logic                   mosi_s;
    logic                   rise_s;
    logic                   fall_s;
    logic                   edge_s;
    logic                   expire_s;

    state_t                 state_r;
    state_t                 state_nxt_s;

    logic [7:0]             shift_r;
    logic [2:0]             bit_cnt_r;
    logic [TW-1:0]          timer_r;
    logic [7:0]             echo_r;
    logic                   miso_r;
    logic [7:0]             rx_data_r;
    logic                   rx_valid_r;
    logic [9:0]             match_count_r;
    logic [9:0]             err_count_r;
    logic [9:0]             byte_count_r;
    logic                   frame_done_r;
    logic                   frag_err_r;

    logic                   shift_en_s;
    logic                   byte_done_s;
    logic [7:0]             byte_s;
    logic                   match_s;
    logic                   last_byte_s;
    logic                   miso_nxt_s;

    // Input synchronisers plus SCLK history; history resets to the idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_r <= {SYNC_STAGES{bus.mode_select}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
            sclk_hist_r <= bus.mode_select;
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], bus.spi_clk};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], bus.spi_mosi};
            sclk_hist_r <= sclk_sync_r[SYNC_STAGES-1];
        end
    end

    // Edge detect and mid-byte timeout; an edge always beats expiry.
    always_comb begin
        sclk_s   = sclk_sync_r[SYNC_STAGES-1];
        mosi_s   = mosi_sync_r[SYNC_STAGES-1];
        rise_s   = sclk_s & ~sclk_hist_r;
        fall_s   = ~sclk_s & sclk_hist_r;
        edge_s   = rise_s | fall_s;
        if (bus.rx_en && (state_r == ST_SHIFT) && !edge_s && (timer_r == TO_ZERO)) begin
            expire_s = 1'b1;
        end else begin
            expire_s = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic: rx_en low dominates, then timeout, then edges.
    always_comb begin
        state_nxt_s = state_r;
        last_byte_s = (byte_count_r == LAST_IDX);
        case (state_r)
            ST_IDLE: begin
                if (!bus.rx_en) begin
                    state_nxt_s = ST_IDLE;
                end else if (rise_s) begin
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (!bus.rx_en || expire_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (rise_s && (bit_cnt_r == 3'd7)) begin
                    state_nxt_s = last_byte_s ? ST_DONE : ST_IDLE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (!bus.rx_en) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM output strobes and next MISO value.
    always_comb begin
        byte_s      = {shift_r[6:0], mosi_s};
        match_s     = (byte_s == byte_count_r[7:0]);
        shift_en_s  = 1'b0;
        byte_done_s = 1'b0;
        miso_nxt_s  = miso_r;
        if (bus.rx_en && rise_s && ((state_r == ST_IDLE) || (state_r == ST_SHIFT))) begin
            shift_en_s  = 1'b1;
            byte_done_s = (state_r == ST_SHIFT) && (bit_cnt_r == 3'd7);
        end else begin
            shift_en_s  = 1'b0;
            byte_done_s = 1'b0;
        end
        if (!bus.rx_en || (state_r == ST_DONE) || (state_nxt_s == ST_DONE)) begin
            miso_nxt_s = 1'b1;
        end else if (fall_s) begin
            miso_nxt_s = echo_bit(echo_r, bit_cnt_r);
        end else begin
            miso_nxt_s = miso_r;
        end
    end

    // Idle timer: reloads on every SCLK edge, counts down only mid-byte.
    always_ff @(posedge clk) begin
        if (rst || !bus.rx_en) begin
            timer_r <= TO_RELOAD;
        end else if (edge_s) begin
            timer_r <= TO_RELOAD;
        end else if ((state_r == ST_SHIFT) && (timer_r != TO_ZERO)) begin
            timer_r <= timer_r - TO_ONE;
        end else begin
            timer_r <= timer_r;
        end
    end

    // Shift datapath, byte checking, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r       <= 8'h00;
            bit_cnt_r     <= 3'd0;
            echo_r        <= 8'hFF;
            miso_r        <= 1'b1;
            rx_data_r     <= 8'h00;
            rx_valid_r    <= 1'b0;
            match_count_r <= 10'd0;
            err_count_r   <= 10'd0;
            byte_count_r  <= 10'd0;
            frame_done_r  <= 1'b0;
            frag_err_r    <= 1'b0;
        end else begin
            rx_valid_r <= byte_done_s;
            frag_err_r <= expire_s;
            miso_r     <= miso_nxt_s;
            if (!bus.rx_en) begin
                shift_r       <= 8'h00;
                bit_cnt_r     <= 3'd0;
                echo_r        <= 8'hFF;
                match_count_r <= 10'd0;
                err_count_r   <= 10'd0;
                byte_count_r  <= 10'd0;
                frame_done_r  <= 1'b0;
            end else if (expire_s) begin
                shift_r   <= 8'h00;
                bit_cnt_r <= 3'd0;
            end else if (shift_en_s) begin
                shift_r   <= byte_s;
                bit_cnt_r <= bit_cnt_r + 3'd1;
                if (byte_done_s) begin
                    rx_data_r    <= byte_s;
                    echo_r       <= byte_s;
                    byte_count_r <= byte_count_r + 10'd1;
                    frame_done_r <= last_byte_s;
                    if (match_s) begin
                        match_count_r <= match_count_r + 10'd1;
                    end else begin
                        err_count_r <= err_count_r + 10'd1;
                    end
                end else begin
                    rx_data_r <= rx_data_r;
                end
            end else begin
                shift_r   <= shift_r;
                bit_cnt_r <= bit_cnt_r;
            end
        end
    end

    assign bus.spi_miso    = miso_r;
    assign bus.rx_data     = rx_data_r;
    assign bus.rx_valid    = rx_valid_r;
    assign bus.match_count = match_count_r;
    assign bus.err_count   = err_count_r;
    assign bus.byte_count  = byte_count_r;
    assign bus.frame_done  = frame_done_r;
    assign bus.frag_err    = frag_err_r;

endmodule

// File: tb/tb_spi_slave_checker.sv
// Self-checking bench for spi_slave_checker: directed SPI traffic with a
// received-byte scoreboard, MISO echo capture and status checks.
module tb_spi_slave_checker;

    localparam int SS = 2;
    localparam int TO = 16;
    localparam int FB = 512;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_slave_checker_if ifc();

    spi_slave_checker #(.SYNC_STAGES(SS), .IDLE_TIMEOUT(TO), .FRAME_BYTES(FB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         frag_seen = 0;
    int         rv_count  = 0;
    logic [7:0] exp_q[$];
    logic       miso_bits[$];
    logic       miso_chk = 1'b0;
    logic [4:0] sclk_hist = 5'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every rx_valid pops one expected byte.
    always @(negedge clk) begin
        if (ifc.rx_valid === 1'b1) begin
            rv_count++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rx_unexpected: got rx_valid with rx_data %0h, expected none", ifc.rx_data);
            end else begin
                check("rx_data", 32'(ifc.rx_data), 32'(exp_q.pop_front()));
            end
        end
        if (ifc.frag_err === 1'b1) frag_seen++;
    end

    // MISO capture four clocks after each SCLK fall at the pins.
    always @(posedge clk) sclk_hist <= {sclk_hist[3:0], ifc.spi_clk};
    always @(negedge clk) begin
        if (miso_chk && sclk_hist[4] && !sclk_hist[3]) miso_bits.push_back(ifc.spi_miso);
    end

    task automatic do_reset(input logic m);
        rst = 1'b1;
        ifc.mode_select = m;
        ifc.spi_clk = m;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One byte MSB first; optional stretched low phase before bit gap_bit's rise.
    task automatic send_byte(input logic [7:0] b, input int gap_bit, input int gap);
        for (int i = 7; i >= 0; i--) begin
            ifc.spi_clk = 1'b0;
            ifc.spi_mosi = b[i];
            tick();
            if (i == gap_bit) repeat (gap - 1) tick();
            ifc.spi_clk = 1'b1;
            tick();
        end
        if (ifc.mode_select == 1'b0) begin
            ifc.spi_clk = 1'b0;
            tick();
        end
    endtask

    task automatic send(input logic [7:0] b, input logic expect_rx);
        if (expect_rx) exp_q.push_back(b);
        send_byte(b, -1, 1);
    endtask

    // n rising edges then leave SCLK low (the fall is the last edge).
    task automatic partial(input int n);
        for (int i = 0; i < n; i++) begin
            ifc.spi_clk = 1'b0;
            ifc.spi_mosi = 1'b1;
            tick();
            ifc.spi_clk = 1'b1;
            tick();
        end
        ifc.spi_clk = 1'b0;
    endtask

    task automatic drain();
        repeat (8) tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_counts(input string tag, input int m, input int e, input int b);
        check({tag, "_match"}, 32'(ifc.match_count), 32'(m));
        check({tag, "_err"},   32'(ifc.err_count),   32'(e));
        check({tag, "_bytes"}, 32'(ifc.byte_count),  32'(b));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        int         f0;
        int         rv0;
        logic [7:0] mb;

        rst = 1'b1;
        ifc.rx_en = 1'b0;
        ifc.mode_select = 1'b0;
        ifc.spi_clk = 1'b0;
        ifc.spi_mosi = 1'b0;
        do_reset(1'b0);

        // Reset state
        check("rst_miso", 32'(ifc.spi_miso), 32'd1);
        check("rst_rx_valid", 32'(ifc.rx_valid), 32'd0);
        check("rst_frame_done", 32'(ifc.frame_done), 32'd0);
        check("rst_frag_err", 32'(ifc.frag_err), 32'd0);
        check("rst_rx_data", 32'(ifc.rx_data), 32'd0);
        check_counts("rst", 0, 0, 0);

        // Mode 0: 00,01,02 with MISO echo
        ifc.rx_en = 1'b1;
        tick();
        check("miso_before_byte0", 32'(ifc.spi_miso), 32'd1);
        miso_chk = 1'b1;
        send(8'h00, 1'b1);
        send(8'h01, 1'b1);
        send(8'h02, 1'b1);
        drain();
        miso_chk = 1'b0;
        check_counts("mode0", 3, 0, 3);
        check("miso_falls", 32'(miso_bits.size()), 32'd24);
        if (miso_bits.size() == 24) begin
            mb = 8'h80;
            for (int i = 0; i < 7; i++) mb[6-i] = miso_bits[i];
            check("miso_byte1", 32'(mb), 32'hFF);
            mb[7] = miso_bits[7];
            for (int i = 0; i < 7; i++) mb[6-i] = miso_bits[8+i];
            check("miso_byte2", 32'(mb), 32'h00);
            mb[7] = miso_bits[15];
            for (int i = 0; i < 7; i++) mb[6-i] = miso_bits[16+i];
            check("miso_byte3", 32'(mb), 32'h01);
            check("miso_next_msb", 32'(miso_bits[23]), 32'd0);
        end

        // Mode 1: idle high, 00 then A5
        do_reset(1'b1);
        send(8'h00, 1'b1);
        send(8'hA5, 1'b1);
        drain();
        check("mode1_rx_data", 32'(ifc.rx_data), 32'hA5);
        check_counts("mode1", 1, 1, 2);

        // Full frame and a byte beyond it
        do_reset(1'b0);
        for (int k = 0; k < FB; k++) send(8'(k), 1'b1);
        drain();
        check_counts("frame", FB, 0, FB);
        check("frame_done", 32'(ifc.frame_done), 32'd1);
        check("done_miso", 32'(ifc.spi_miso), 32'd1);
        rv0 = rv_count;
        send(8'h00, 1'b0);
        drain();
        check("extra_no_rx_valid", 32'(rv_count), 32'(rv0));
        check_counts("extra", FB, 0, FB);
        check("extra_frame_done", 32'(ifc.frame_done), 32'd1);
        check("extra_miso", 32'(ifc.spi_miso), 32'd1);

        // Timeout after 5 bits
        do_reset(1'b0);
        f0 = frag_seen;
        partial(5);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (ifc.frag_err === 1'b1 && lat == 0) lat = k;
        end
        check("frag_latency", 32'(lat), 32'(TO + SS + 1));
        check("frag_pulses", 32'(frag_seen - f0), 32'd1);
        check_counts("frag", 0, 0, 0);
        send(8'h00, 1'b1);
        drain();
        check_counts("after_frag", 1, 0, 1);

        // Reset mid-byte at bit 3
        do_reset(1'b0);
        f0 = frag_seen;
        send(8'h00, 1'b1);
        send(8'h01, 1'b1);
        drain();
        partial(4);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_rx_data", 32'(ifc.rx_data), 32'd0);
        check("midrst_miso", 32'(ifc.spi_miso), 32'd1);
        check("midrst_rx_valid", 32'(ifc.rx_valid), 32'd0);
        check_counts("midrst", 0, 0, 0);
        send(8'h00, 1'b1);
        drain();
        check_counts("after_rst", 1, 0, 1);

        // rx_en drop mid-byte at bit 3
        send(8'h01, 1'b1);
        drain();
        partial(4);
        repeat (4) tick();
        ifc.rx_en = 1'b0;
        tick();
        check("rxen_rx_data_held", 32'(ifc.rx_data), 32'h01);
        check("rxen_miso", 32'(ifc.spi_miso), 32'd1);
        check("rxen_frame_done", 32'(ifc.frame_done), 32'd0);
        check_counts("rxen", 0, 0, 0);
        ifc.rx_en = 1'b1;
        tick();
        send(8'h00, 1'b1);
        drain();
        check_counts("after_rxen", 1, 0, 1);
        check("no_frag_on_abort", 32'(frag_seen - f0), 32'd0);

        // Rise coincident with timeout expiry
        do_reset(1'b0);
        f0 = frag_seen;
        exp_q.push_back(8'h08);
        send_byte(8'h08, 3, TO);
        drain();
        check("coincident_frag", 32'(frag_seen - f0), 32'd0);
        check_counts("coincident", 0, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
